issue_select: RTL

- Select/read end of the issue-slot protocol: one instance per issue queue.
- Each cycle it picks one requesting slot round-robin and drives a one-hot grant, which enables that slot's payload onto the shared tristate read bus in the same cycle.
- It captures the payload into an output register and hands it to the execution pipe with a valid/ready handshake.
- It drops held or captured uops hit by a branch kill.

---
 rtl/issue_select_pkg.sv | 36 +++
 rtl/issue_select_rr_arbiter.sv | 39 +++
 rtl/issue_select.sv | 77 +++++++
 3 files changed

// File: rtl/issue_select_pkg.sv
// Shared payload layout for the issue path (issue_slot, dispatch, issue_select).
// Payload is {uop[6:0], brmask, tag, rd, rs2, rs1}, MSB to LSB.
package issue_select_pkg;

  localparam int WIDTH_REG = 5;
  localparam int WIDTH_TAG = 5;
  localparam int WIDTH_BRM = 3;
  localparam int WIDTH_UOP = 7;
  localparam int WIDTH_PL  = WIDTH_UOP + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG;

  localparam int RS1_LSB = 0;
  localparam int RS1_MSB = RS1_LSB + WIDTH_REG - 1;
  localparam int RS2_LSB = RS1_MSB + 1;
  localparam int RS2_MSB = RS2_LSB + WIDTH_REG - 1;
  localparam int RD_LSB  = RS2_MSB + 1;
  localparam int RD_MSB  = RD_LSB + WIDTH_REG - 1;
  localparam int TAG_LSB = RD_MSB + 1;
  localparam int TAG_MSB = TAG_LSB + WIDTH_TAG - 1;
  localparam int BRM_LSB = TAG_MSB + 1;
  localparam int BRM_MSB = BRM_LSB + WIDTH_BRM - 1;
  localparam int UOP_LSB = BRM_MSB + 1;
  localparam int UOP_MSB = WIDTH_PL - 1;

  typedef logic [WIDTH_PL-1:0]  payload_t;
  typedef logic [WIDTH_BRM-1:0] brmask_t;

  function automatic brmask_t pl_brmask(input payload_t pl);
    return pl[BRM_MSB:BRM_LSB];
  endfunction

  // A uop is squashed when any of its branch dependencies is being killed.
  function automatic logic br_hit(input brmask_t mask, input brmask_t kill);
    return |(mask & kill);
  endfunction

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// Round-robin arbiter: rotate requests so ptr lands at bit 0, pick the lowest set
// bit, then rotate the result back. N must be a power of two.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic           found_s;
  logic [PW-1:0]  off_s;

  always_comb begin
    dbl_s   = {req_i, req_i} >> ptr_i;
    rot_s   = dbl_s[N-1:0];
    found_s = 1'b0;
    off_s   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_s && rot_s[i]) begin
        found_s = 1'b1;
        off_s   = PW'(i);
      end
    end
    // Offset plus ptr wraps naturally because N is a power of two.
    idx_o = ptr_i + off_s;
    if (en_i && found_s) begin
      gnt_o = {{(N-1){1'b0}}, 1'b1} << idx_o;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/issue_select.sv
// Select/read end of an issue queue: round-robin grant onto the shared read bus,
// capture into an output register, valid/ready handoff, branch-kill squash.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int SLOTS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SLOTS-1:0]     i_request,
  output logic [SLOTS-1:0]     o_grant,
  input  logic [WIDTH_PL-1:0]  i_rslot,
  input  logic [WIDTH_BRM-1:0] i_BrKill,
  output logic                 o_valid,
  output logic [WIDTH_PL-1:0]  o_uop,
  input  logic                 i_ready
);

  localparam int PTR_W = $clog2(SLOTS);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  payload_t         uop_q, uop_d;

  logic             held_kill_s;
  logic             accept_s;
  logic [SLOTS-1:0] gnt_s;
  logic [PTR_W-1:0] idx_s;

  assign held_kill_s = valid_q & br_hit(pl_brmask(uop_q), i_BrKill);
  assign accept_s    = ~valid_q | i_ready | held_kill_s;

  rr_arbiter #(
    .N  (SLOTS),
    .PW (PTR_W)
  ) u_arb (
    .req_i (i_request),
    .ptr_i (ptr_q),
    .en_i  (accept_s & ~i_rst),
    .gnt_o (gnt_s),
    .idx_o (idx_s)
  );

  assign o_grant = gnt_s;

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    uop_d   = uop_q;
    if (|gnt_s) begin
      // A uop killed on capture is consumed from its slot but never issued.
      uop_d   = i_rslot;
      valid_d = ~br_hit(pl_brmask(i_rslot), i_BrKill);
      ptr_d   = idx_s + PTR_W'(1);
    end else if (i_ready || held_kill_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      uop_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      uop_q   <= uop_d;
    end
  end

  assign o_valid = valid_q;
  assign o_uop   = uop_q;

endmodule
